piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Downstream stage of the 8-bit shift register: takes its parallel word and serializes it onto a single-bit stream with framing strobes, using a valid/ready handshake.
- A one-word holding buffer lets back-to-back words stream with no idle bit between them.
- Direction (MSB-first or LSB-first) uses the same r_l control as the shift register, captured once per word.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  parallel word from the upstream shift register
din_valid  input  1  din holds a word to transfer
din_ready  output  1  holding buffer empty; transfer when din_valid & din_ready at the rising edge
r_l  input  1  sampled with din; 0 = MSB first (shift left), 1 = LSB first (shift right)
sout  output  1  serial data bit
sout_valid  output  1  sout carries a word bit this cycle
sof  output  1  first bit of a word
eof  output  1  last bit of a word
busy  output  1  shifter active or holding buffer full

Behaviour:
- Reset is asynchronous on rst_n low.
  - Clears the shifter, holding buffer (hb), hb_full, hb_dir, bit counter and state; state goes to IDLE.
  - sout, sout_valid, sof, eof and busy are all 0; din_ready is 1.
  - A word in flight is discarded. Partial words are never resumed.
- din_ready is !hb_full, driven purely from the register with no same-cycle pass-through.
  - While hb is full, din_ready stays low, even in the cycle hb empties.
- Accept: at the edge where din_valid & din_ready, hb <= din, hb_dir <= r_l and hb_full <= 1.
- Load: at an edge where hb_full and (state == IDLE or the last bit is on sout):
  - the shifter takes hb and shifter direction takes hb_dir;
  - the counter goes to 0, state goes to SHIFT and hb_full goes to 0;
  - din_ready returns high the following cycle.
- Latency: a word accepted at edge N, with the shifter idle, shows its first bit on sout after edge N+1.
- State machine:
  - IDLE: sout_valid = 0; go to SHIFT on load.
  - SHIFT: sout_valid = 1. Each edge shifts by one and increments the counter.
  - At counter == WIDTH-1: reload if hb_full (stay in SHIFT, no gap), otherwise go to IDLE.
- Bit selection:
  - Direction 0: sout = shifter[WIDTH-1], shift left with 0 fill.
  - Direction 1: sout = shifter[0], shift right with 0 fill.
  - sout = 0 whenever sout_valid = 0.
- Framing: sof = sout_valid & (counter == 0); eof = sout_valid & (counter == WIDTH-1).
  - For a single word, sof and eof are high in different cycles.
- Direction change: r_l changes between acceptances affect only later words. Toggling r_l mid-word has no effect on the word being shifted.
- Throughput: one word per WIDTH cycles, sustained.
  - With WIDTH >= 2, hb refills during the current word, so the stream stays gapless if upstream keeps din_valid high.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.
- busy = (state == SHIFT) | hb_full.

Decomposition:
- Shared package shift_pkg:
  - state enum {IDLE, SHIFT};
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1, matching the r_l encoding;
  - default WIDTH = 8.
- Single module; no sub-module. The holding buffer and counter are a few registers each.

Test Plan:
- Reset check: rst_n low for 3 cycles -> sout_valid = 0, sof = 0, eof = 0, busy = 0, din_ready = 1. After release, with din_valid = 0 for 10 cycles -> no output activity.
- MSB-first word: din = 8'hB4, r_l = 0, one transfer -> sout = 1,0,1,1,0,1,0,0 on 8 consecutive cycles. sof is on bit 1 and eof on bit 8; sout_valid then falls.
- LSB-first word: din = 8'hB4, r_l = 1 -> sout = 0,0,1,0,1,1,0,1. Toggling r_l during bits 3-5 leaves the sequence unchanged.
- Back-to-back words: 8'h3C (r_l = 0) then 8'hC3 (r_l = 1), din_valid held high -> 16 contiguous sout_valid cycles, with eof of word 1 immediately followed by sof of word 2.
  - Expected sout: 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1.
- Backpressure: three words 8'h01, 8'h02, 8'h03 with din_valid held high.
  - din_ready falls after word 2 is accepted, and rises the cycle after word 2 loads at word 1's final bit.
  - No word is lost or duplicated.
- Reset mid-operation: assert rst_n on the 4th bit of 8'hFF.
  - sout_valid drops immediately (asynchronous) and din_ready goes to 1.
  - The next word 8'h81 (r_l = 0) serializes fully and correctly from sof.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register datapath.
// Used by the parallel-in/serial-out stage.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer.
// Emits framed words back to back, direction chosen per word.
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             r_l,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic             dir, dir_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] hb;
    logic             hb_dir;
    logic             hb_full, hb_full_nx;
    logic             last, load, accept;

    assign last   = (state == SHIFT) && (cnt == LAST);
    assign load   = hb_full && ((state == IDLE) || last);
    assign accept = din_valid && !hb_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            dir     <= DIR_LEFT;
            cnt     <= '0;
            hb_full <= 1'b0;
        end else begin
            state   <= state_nx;
            sh      <= sh_nx;
            dir     <= dir_nx;
            cnt     <= cnt_nx;
            hb_full <= hb_full_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb     <= '0;
            hb_dir <= DIR_LEFT;
        end else if (accept) begin
            hb     <= din;
            hb_dir <= r_l;
        end
    end

    // A load on the last bit keeps SHIFT with no idle slot between words.
    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        dir_nx     = dir;
        cnt_nx     = cnt;
        hb_full_nx = hb_full;
        if (load) begin
            state_nx   = SHIFT;
            sh_nx      = hb;
            dir_nx     = hb_dir;
            cnt_nx     = '0;
            hb_full_nx = 1'b0;
        end else begin
            if (accept) begin
                hb_full_nx = 1'b1;
            end
            unique case (state)
                IDLE: begin
                    cnt_nx = '0;
                end
                SHIFT: begin
                    sh_nx  = (dir == DIR_RIGHT) ? (sh >> 1) : (sh << 1);
                    cnt_nx = cnt + CW'(1);
                    if (last) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid
                      & ((dir == DIR_RIGHT) ? sh[0] : sh[WIDTH-1]);
    assign sof        = sout_valid && (cnt == '0);
    assign eof        = sout_valid && (cnt == LAST);
    assign busy       = (state == SHIFT) || hb_full;
    assign din_ready  = !hb_full;

endmodule
